// File: rtl/hazard_pipeline_ctrl_if.sv
// Control bundle between the pipeline stages and the hazard controller.
// The pipeline side (master) raises requests; the controller (slave) answers with stall/flush/PC control.
interface hazard_pipeline_ctrl_if #(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_REDIRECT = 2,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32
);
    localparam int SEL_WIDTH = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0]            stage_stall_req;
    logic [NUM_STAGES-1:0]            stage_flush_req;
    logic [NUM_REDIRECT-1:0]          redirect_valid;
    logic [NUM_REDIRECT*PC_WIDTH-1:0] redirect_pc;
    logic                             recover_req;
    logic [PC_WIDTH-1:0]              recover_pc;
    logic [NUM_STAGES-1:0]            stall;
    logic [NUM_STAGES-1:0]            flush;
    logic                             load_pc_we;
    logic [PC_WIDTH-1:0]              load_pc;
    logic                             restore_snapshot;
    logic                             recover_busy;
    logic [SEL_WIDTH-1:0]             stat_sel;
    logic                             stat_clear;
    logic [CNT_WIDTH-1:0]             stat_stall_cnt;
    logic [CNT_WIDTH-1:0]             stat_flush_cnt;

    modport master (
        output stage_stall_req, stage_flush_req, redirect_valid, redirect_pc,
               recover_req, recover_pc, stat_sel, stat_clear,
        input  stall, flush, load_pc_we, load_pc, restore_snapshot, recover_busy,
               stat_stall_cnt, stat_flush_cnt
    );

    modport slave (
        input  stage_stall_req, stage_flush_req, redirect_valid, redirect_pc,
               recover_req, recover_pc, stat_sel, stat_clear,
        output stall, flush, load_pc_we, load_pc, restore_snapshot, recover_busy,
               stat_stall_cnt, stat_flush_cnt
    );
endinterface

// File: rtl/hazard_pipeline_ctrl.sv
// N-stage stall/flush controller: stall chain, redirect arbitration, value-prediction
// recovery sequencing and saturating per-stage stall/flush statistics.
module hazard_pipeline_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int NUM_REDIRECT   = 2,
    parameter int PC_WIDTH       = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_WIDTH      = 32
) (
    input logic                   clk,
    input logic                   rst,
    hazard_pipeline_ctrl_if.slave bus
);
    localparam int N           = NUM_STAGES;
    localparam int DRAIN_WIDTH = (RECOVER_CYCLES > 2) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [DRAIN_WIDTH-1:0] DRAIN_INIT =
        DRAIN_WIDTH'((RECOVER_CYCLES > 1) ? RECOVER_CYCLES - 2 : 0);

    typedef enum logic [1:0] {IDLE, RESTORE, DRAIN} state_t;

    state_t                 state, state_next;
    logic [DRAIN_WIDTH-1:0] drain_cnt, drain_next;
    logic                   restore_exit;

    logic [N-1:0] raw_hold;
    logic [N-1:0] squash;
    logic [N-1:0] stall_c;
    logic [N-1:0] flush_c;
    logic         redirect_ok;
    logic         win_found;
    int           win_idx;

    logic [CNT_WIDTH-1:0] stall_cnt [N];
    logic [CNT_WIDTH-1:0] flush_cnt [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next   = state;
        drain_next   = drain_cnt;
        restore_exit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.recover_req) state_next = RESTORE;
            end
            RESTORE: begin
                if (!bus.stage_stall_req[N-1]) begin
                    restore_exit = 1'b1;
                    if (RECOVER_CYCLES > 1) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_INIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_next = IDLE;
                else                 drain_next = drain_cnt - DRAIN_WIDTH'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // raw_hold ignores redirect squashing; it only decides whether the winner's stage can move.
    always_comb begin
        raw_hold    = '0;
        squash      = '0;
        stall_c     = '0;
        flush_c     = '0;
        win_idx     = 0;
        win_found   = 1'b0;
        redirect_ok = 1'b0;

        raw_hold[N-1] = bus.stage_stall_req[N-1];
        for (int i = N - 2; i >= 0; i--)
            raw_hold[i] = bus.stage_stall_req[i] | bus.stage_flush_req[i+1] | raw_hold[i+1];

        for (int k = 0; k < NUM_REDIRECT; k++) begin
            if (bus.redirect_valid[k]) begin
                win_idx   = k;
                win_found = 1'b1;
            end
        end
        redirect_ok = win_found && (state == IDLE) && !raw_hold[win_idx+1];

        for (int i = 0; i < N; i++)
            squash[i] = redirect_ok && (i <= win_idx);

        stall_c[N-1] = bus.stage_stall_req[N-1] & ~squash[N-1];
        for (int i = N - 2; i >= 0; i--)
            stall_c[i] = (bus.stage_stall_req[i] & ~squash[i]) | bus.stage_flush_req[i+1] | stall_c[i+1];

        // The bottom of a stall chain emits a bubble; a held register downstream blocks it.
        for (int i = 0; i < N; i++)
            flush_c[i] = bus.stage_flush_req[i] | stall_c[i] | squash[i];
        for (int i = 0; i < N - 1; i++)
            if (stall_c[i+1]) flush_c[i] = 1'b0;

        if (restore_exit) begin
            stall_c = '0;
            for (int i = 0; i < N - 1; i++) flush_c[i] = 1'b1;
        end
        if (state == DRAIN) begin
            stall_c[0] = 1'b1;
            flush_c[0] = 1'b1;
        end
    end

    always_comb begin
        bus.stall            = stall_c;
        bus.flush            = flush_c;
        bus.load_pc_we       = 1'b0;
        bus.load_pc          = '0;
        bus.restore_snapshot = restore_exit;
        bus.recover_busy     = (state != IDLE);
        if (restore_exit) begin
            bus.load_pc_we = 1'b1;
            bus.load_pc    = bus.recover_pc;
        end else if (redirect_ok) begin
            bus.load_pc_we = 1'b1;
            bus.load_pc    = bus.redirect_pc[win_idx*PC_WIDTH +: PC_WIDTH];
        end
        if (rst) begin
            bus.stall            = '0;
            bus.flush            = '1;
            bus.load_pc_we       = 1'b0;
            bus.load_pc          = '0;
            bus.restore_snapshot = 1'b0;
            bus.recover_busy     = 1'b0;
        end
    end

    // The readout samples the counters before this cycle's increment or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stall_cnt[i] <= '0;
                flush_cnt[i] <= '0;
            end
            bus.stat_stall_cnt <= '0;
            bus.stat_flush_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.stat_clear)
                    stall_cnt[i] <= '0;
                else if (stall_c[i] && (stall_cnt[i] != '1))
                    stall_cnt[i] <= stall_cnt[i] + CNT_WIDTH'(1);
                if (bus.stat_clear)
                    flush_cnt[i] <= '0;
                else if (flush_c[i] && (flush_cnt[i] != '1))
                    flush_cnt[i] <= flush_cnt[i] + CNT_WIDTH'(1);
            end
            if (int'(bus.stat_sel) < N) begin
                bus.stat_stall_cnt <= stall_cnt[bus.stat_sel];
                bus.stat_flush_cnt <= flush_cnt[bus.stat_sel];
            end else begin
                bus.stat_stall_cnt <= '0;
                bus.stat_flush_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard_pipeline_ctrl.sv
// Bench for hazard_pipeline_ctrl: directed scenarios then random traffic, every cycle compared
// against a rule-level reference model of stalls, bubbles, redirects, recovery and statistics.
module tb_hazard_pipeline_ctrl;
    localparam int N    = 5;
    localparam int NR   = 2;
    localparam int PCW  = 32;
    localparam int RC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    hazard_pipeline_ctrl_if #(.NUM_STAGES(N), .NUM_REDIRECT(NR), .PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

    hazard_pipeline_ctrl #(
        .NUM_STAGES(N), .NUM_REDIRECT(NR), .PC_WIDTH(PCW), .RECOVER_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state: phase 0 idle, 1 restoring, 2 draining.
    int m_phase = 0;
    int m_drain_left = 0;
    int m_stall_cnt [N];
    int m_flush_cnt [N];
    int m_stat_s = 0;
    int m_stat_f = 0;
    bit m_known = 1'b0;

    logic [N-1:0]   exp_stall;
    logic [N-1:0]   exp_flush;
    logic           exp_we;
    logic [PCW-1:0] exp_pc;
    logic           exp_snap;
    logic           exp_busy;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit held_from(int i, logic [N-1:0] req, logic [N-1:0] freq);
        bit h = 1'b0;
        for (int j = i; j < N; j++) if (req[j]) h = 1'b1;
        for (int j = i + 1; j < N; j++) if (freq[j]) h = 1'b1;
        return h;
    endfunction

    task automatic compute_expected();
        int win;
        bit eff;
        bit leave_restore;
        logic [N-1:0] req_left;
        exp_stall = '0;
        exp_flush = '0;
        exp_we    = 1'b0;
        exp_pc    = '0;
        exp_snap  = 1'b0;
        exp_busy  = 1'b0;
        if (rst) begin
            exp_flush = '1;
        end else begin
            exp_busy = (m_phase != 0);
            leave_restore = (m_phase == 1) && !bus.stage_stall_req[N-1];
            win = -1;
            if (m_phase == 0)
                for (int k = 0; k < NR; k++) if (bus.redirect_valid[k]) win = k;
            eff = (win >= 0) && !held_from(win + 1, bus.stage_stall_req, bus.stage_flush_req);
            req_left = bus.stage_stall_req;
            for (int j = 0; j < N; j++) if (eff && j <= win) req_left[j] = 1'b0;
            for (int i = 0; i < N; i++)
                exp_stall[i] = held_from(i, req_left, bus.stage_flush_req);
            for (int i = 0; i < N; i++) begin
                exp_flush[i] = bus.stage_flush_req[i] || exp_stall[i] || (eff && i <= win);
                if (i < N - 1 && exp_stall[i+1]) exp_flush[i] = 1'b0;
            end
            if (eff) begin
                exp_we = 1'b1;
                exp_pc = bus.redirect_pc[win*PCW +: PCW];
            end
            if (leave_restore) begin
                exp_stall = '0;
                for (int i = 0; i < N - 1; i++) exp_flush[i] = 1'b1;
                exp_we   = 1'b1;
                exp_pc   = bus.recover_pc;
                exp_snap = 1'b1;
            end
            if (m_phase == 2) begin
                exp_stall[0] = 1'b1;
                exp_flush[0] = 1'b1;
            end
        end
    endtask

    task automatic update_model();
        int sel;
        if (rst) begin
            m_phase = 0;
            m_drain_left = 0;
            for (int i = 0; i < N; i++) begin
                m_stall_cnt[i] = 0;
                m_flush_cnt[i] = 0;
            end
            m_stat_s = 0;
            m_stat_f = 0;
            m_known  = 1'b1;
        end else begin
            sel = int'(bus.stat_sel);
            m_stat_s = (sel < N) ? m_stall_cnt[sel] : 0;
            m_stat_f = (sel < N) ? m_flush_cnt[sel] : 0;
            for (int i = 0; i < N; i++) begin
                if (bus.stat_clear) begin
                    m_stall_cnt[i] = 0;
                    m_flush_cnt[i] = 0;
                end else begin
                    if (exp_stall[i] && m_stall_cnt[i] < CMAX) m_stall_cnt[i]++;
                    if (exp_flush[i] && m_flush_cnt[i] < CMAX) m_flush_cnt[i]++;
                end
            end
            case (m_phase)
                0: if (bus.recover_req) m_phase = 1;
                1: if (!bus.stage_stall_req[N-1]) begin
                       if (RC > 1) begin
                           m_phase = 2;
                           m_drain_left = RC - 1;
                       end else begin
                           m_phase = 0;
                       end
                   end
                default: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_phase = 0;
                end
            endcase
        end
    endtask

    // One clock: compare every output mid-cycle, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        compute_expected();
        check_output("stall", 32'(bus.stall), 32'(exp_stall));
        check_output("flush", 32'(bus.flush), 32'(exp_flush));
        check_output("load_pc_we", 32'(bus.load_pc_we), 32'(exp_we));
        check_output("load_pc", bus.load_pc, exp_pc);
        check_output("restore_snapshot", 32'(bus.restore_snapshot), 32'(exp_snap));
        check_output("recover_busy", 32'(bus.recover_busy), 32'(exp_busy));
        if (m_known) begin
            check_output("stat_stall_cnt", 32'(bus.stat_stall_cnt), 32'(m_stat_s));
            check_output("stat_flush_cnt", 32'(bus.stat_flush_cnt), 32'(m_stat_f));
        end
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic apply_stimulus();
        rst = ($urandom_range(0, 63) == 0);
        for (int i = 0; i < N; i++) begin
            bus.stage_stall_req[i] = ($urandom_range(0, 3) == 0);
            bus.stage_flush_req[i] = ($urandom_range(0, 7) == 0);
        end
        for (int k = 0; k < NR; k++) begin
            bus.redirect_valid[k] = ($urandom_range(0, 2) == 0);
            bus.redirect_pc[k*PCW +: PCW] = $urandom;
        end
        bus.recover_req = ($urandom_range(0, 15) == 0);
        bus.recover_pc  = $urandom;
        bus.stat_sel    = 3'($urandom_range(0, 7));
        bus.stat_clear  = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stage_stall_req = '0;
        bus.stage_flush_req = '0;
        bus.redirect_valid  = '0;
        bus.redirect_pc     = '0;
        bus.recover_req     = 1'b0;
        bus.recover_pc      = '0;
        bus.stat_sel        = '0;
        bus.stat_clear      = 1'b0;

        // Reset held for three cycles.
        repeat (3) cycle();
        #1;
        check_output("reset_stall", 32'(bus.stall), 32'h0);
        check_output("reset_flush", 32'(bus.flush), 32'h1f);
        check_output("reset_we", 32'(bus.load_pc_we), 32'h0);
        check_output("reset_stat", 32'(bus.stat_stall_cnt), 32'h0);
        rst = 1'b0;

        // MEM stall propagates to every stage; only the MEM bubble survives.
        bus.stage_stall_req = 5'b10000;
        #1;
        check_output("mem_stall_chain", 32'(bus.stall), 32'h1f);
        check_output("mem_stall_flush", 32'(bus.flush), 32'h10);
        repeat (4) cycle();
        bus.stage_stall_req = '0;
        bus.stat_sel = 3'd4;
        cycle();
        #1;
        check_output("stat_mem_stall4", 32'(bus.stat_stall_cnt), 32'd4);

        // Older redirect wins and beats an IF miss.
        bus.stage_stall_req = 5'b00001;
        bus.redirect_valid  = 2'b11;
        bus.redirect_pc     = {32'h200, 32'h100};
        #1;
        check_output("redir_we", 32'(bus.load_pc_we), 32'h1);
        check_output("redir_pc", bus.load_pc, 32'h200);
        check_output("redir_flush10", 32'(bus.flush[1:0]), 32'h3);
        check_output("redir_if_unstalled", 32'(bus.stall[0]), 32'h0);
        cycle();

        // Redirect held while its downstream stage is stalled.
        bus.redirect_valid  = 2'b10;
        bus.stage_stall_req = 5'b01000;
        #1;
        check_output("redir_blocked", 32'(bus.load_pc_we), 32'h0);
        repeat (2) cycle();
        bus.stage_stall_req = '0;
        #1;
        check_output("redir_released", 32'(bus.load_pc_we), 32'h1);
        check_output("redir_released_pc", bus.load_pc, 32'h200);
        cycle();
        bus.redirect_valid = '0;

        // Recovery sequence; redirects and repeat requests are ignored while busy.
        bus.recover_req = 1'b1;
        bus.recover_pc  = 32'h400;
        cycle();
        bus.recover_req    = 1'b0;
        bus.redirect_valid = 2'b11;
        #1;
        check_output("rec_snapshot", 32'(bus.restore_snapshot), 32'h1);
        check_output("rec_pc", bus.load_pc, 32'h400);
        check_output("rec_flush", 32'(bus.flush), 32'h0f);
        cycle();
        bus.redirect_valid = '0;
        bus.recover_req    = 1'b1;
        #1;
        check_output("drain_flush0", 32'(bus.flush[0]), 32'h1);
        check_output("drain_busy", 32'(bus.recover_busy), 32'h1);
        cycle();
        bus.recover_req = 1'b0;
        #1;
        check_output("rec_done_idle", 32'(bus.recover_busy), 32'h0);
        cycle();

        // Reset while stuck in RESTORE.
        bus.recover_req = 1'b1;
        cycle();
        bus.recover_req     = 1'b0;
        bus.stage_stall_req = 5'b10000;
        cycle();
        #1;
        check_output("restore_waiting", 32'(bus.recover_busy), 32'h1);
        rst = 1'b1;
        bus.stage_stall_req = '0;
        #1;
        check_output("rst_no_snapshot", 32'(bus.restore_snapshot), 32'h0);
        cycle();
        rst = 1'b0;
        #1;
        check_output("rst_back_idle", 32'(bus.recover_busy), 32'h0);

        // Counter saturation and clear priority.
        bus.stage_stall_req = 5'b00001;
        repeat (20) cycle();
        bus.stat_sel = 3'd0;
        cycle();
        #1;
        check_output("stall_saturated", 32'(bus.stat_stall_cnt), 32'd15);
        check_output("flush_saturated", 32'(bus.stat_flush_cnt), 32'd15);
        bus.stat_clear = 1'b1;
        cycle();
        bus.stat_clear = 1'b0;
        cycle();
        #1;
        check_output("clear_wins", 32'(bus.stat_stall_cnt), 32'd0);
        bus.stage_stall_req = '0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
